// File: rtl/vx_packet_arb_pkg.sv
// Shared types for the packet-aware stream arbiter.
//   packet_arb_state_t : scheduler FSM state (idle / locked on one requester's packet)
package vx_packet_arb_pkg;

  typedef enum logic {
    PKT_ARB_IDLE   = 1'b0,
    PKT_ARB_LOCKED = 1'b1
  } packet_arb_state_t;

endpackage

// File: rtl/vx_packet_arb_sched.sv
// Grant scheduler for vx_packet_arb: FSM, round-robin pointer, packet quota
// counter and lock index. Produces the grant (one-hot and index). Carries no payload.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   valid_in        per-requester beat valid
//   last_in         per-requester end-of-packet flag
//   arb_ready       ready of the output stage; a grant fires when it is high
//   grant_onehot    one-hot grant (zero when nothing can fire)
//   grant_idx       index of the granted requester
//   grant_valid     granted requester has a beat this cycle
//   perf_hol_stalls head-of-line stall counter (only with VX_PACKET_ARB_PERF_EN)
// Optional feature macro: VX_PACKET_ARB_PERF_EN
module vx_packet_arb_sched
  import vx_packet_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int QUOTA      = 1,
  parameter int SEL_W      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] valid_in,
  input  logic [NUM_INPUTS-1:0] last_in,
  input  logic                  arb_ready,
`ifdef VX_PACKET_ARB_PERF_EN
  output logic [31:0]           perf_hol_stalls,
`endif
  output logic [NUM_INPUTS-1:0] grant_onehot,
  output logic [SEL_W-1:0]      grant_idx,
  output logic                  grant_valid
);

  localparam int QW = (QUOTA > 1) ? $clog2(QUOTA) : 1;
  localparam logic [QW-1:0]    QUOTA_LAST = QW'(QUOTA - 1);
  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_INPUTS - 1);

  packet_arb_state_t state;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  lock_idx;
  logic [SEL_W-1:0]  prev_idx;
  logic [QW-1:0]     quota_cnt;

  logic [SEL_W:0]    cand;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              fire;
  logic [QW-1:0]     eff_cnt;
  logic [SEL_W-1:0]  next_ptr;

  // Round-robin search starting at rr_ptr; iterating from the far end down
  // lets the closest valid requester overwrite the others.
  always_comb begin
    cand       = '0;
    pick_idx   = rr_ptr;
    pick_valid = 1'b0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(NUM_INPUTS))
        cand = cand - (SEL_W+1)'(NUM_INPUTS);
      if (valid_in[cand[SEL_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[SEL_W-1:0];
      end
    end
  end

  // While locked only the lock holder may fire; an idle holder gives a bubble.
  always_comb begin
    grant_idx   = pick_idx;
    grant_valid = pick_valid;
    if (state == PKT_ARB_LOCKED) begin
      grant_idx   = lock_idx;
      grant_valid = valid_in[lock_idx];
    end
    if (reset)
      grant_valid = 1'b0;
    grant_onehot = '0;
    if (grant_valid)
      grant_onehot[grant_idx] = 1'b1;
  end

  assign fire     = grant_valid & arb_ready;
  // A new holder restarts its quota before this packet is counted.
  assign eff_cnt  = (grant_idx == prev_idx) ? quota_cnt : '0;
  assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PKT_ARB_IDLE;
      rr_ptr    <= '0;
      quota_cnt <= '0;
      lock_idx  <= '0;
      prev_idx  <= '0;
    end else if (fire) begin
      if (last_in[grant_idx]) begin
        state    <= PKT_ARB_IDLE;
        prev_idx <= grant_idx;
        if (eff_cnt == QUOTA_LAST) begin
          quota_cnt <= '0;
          rr_ptr    <= next_ptr;
        end else begin
          quota_cnt <= eff_cnt + 1'b1;
          rr_ptr    <= grant_idx;
        end
      end else begin
        state    <= PKT_ARB_LOCKED;
        lock_idx <= grant_idx;
      end
    end
  end

`ifdef VX_PACKET_ARB_PERF_EN
  logic hol_stall;
  // Holder idle mid-packet while somebody else is waiting.
  assign hol_stall = (state == PKT_ARB_LOCKED) && !valid_in[lock_idx] && (|valid_in);

  always_ff @(posedge clk) begin
    if (reset)
      perf_hol_stalls <= '0;
    else if (hol_stall && (perf_hol_stalls != '1))
      perf_hol_stalls <= perf_hol_stalls + 32'd1;
  end
`endif

endmodule

// File: rtl/vx_packet_arb.sv
// Packet-aware N:1 stream arbiter. Grants one requester at a time in round-robin
// order with a per-requester packet quota and holds the grant until the last beat.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   valid_in/data_in/last_in/ready_in  per-requester beat stream (NUM_INPUTS lanes)
//   valid_out/data_out/last_out/ready_out  merged output stream
//   sel_out          index of the requester that produced the output beat
//   perf_hol_stalls  head-of-line stall count (only with VX_PACKET_ARB_PERF_EN)
// OUT_BUF: 0 = combinational pass-through, 1..3 = two-entry elastic buffer with
// registered outputs (full throughput, ready_in no longer depends on ready_out).
// Optional feature macro: VX_PACKET_ARB_PERF_EN
module vx_packet_arb
  import vx_packet_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int DATAW      = 1,
  parameter int QUOTA      = 1,
  parameter int OUT_BUF    = 0,
  localparam int SEL_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       valid_in,
  input  logic [NUM_INPUTS*DATAW-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]       last_in,
  output logic [NUM_INPUTS-1:0]       ready_in,
`ifdef VX_PACKET_ARB_PERF_EN
  output logic [31:0]                 perf_hol_stalls,
`endif
  output logic                        valid_out,
  output logic [DATAW-1:0]            data_out,
  output logic                        last_out,
  output logic [SEL_W-1:0]            sel_out,
  input  logic                        ready_out
);

  localparam int PW = SEL_W + 1 + DATAW;

  logic [NUM_INPUTS-1:0] grant_onehot;
  logic [SEL_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  arb_ready;
  logic [DATAW:0]        mux_ld;
  logic [PW-1:0]         arb_pl;

  vx_packet_arb_sched #(
    .NUM_INPUTS (NUM_INPUTS),
    .QUOTA      (QUOTA),
    .SEL_W      (SEL_W)
  ) sched (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .last_in         (last_in),
    .arb_ready       (arb_ready),
`ifdef VX_PACKET_ARB_PERF_EN
    .perf_hol_stalls (perf_hol_stalls),
`endif
    .grant_onehot    (grant_onehot),
    .grant_idx       (grant_idx),
    .grant_valid     (grant_valid)
  );

  assign ready_in = grant_onehot & {NUM_INPUTS{arb_ready}};

  always_comb begin
    mux_ld = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (grant_onehot[i])
        mux_ld = mux_ld | {last_in[i], data_in[i*DATAW +: DATAW]};
  end

  assign arb_pl = {grant_idx, mux_ld};

  if (OUT_BUF == 0) begin : g_pass
    assign valid_out = grant_valid;
    assign arb_ready = ready_out;
    assign {sel_out, last_out, data_out} = arb_pl;
  end else begin : g_buf
    logic          out_vld_p0;
    logic          skid_vld_p0;
    logic [PW-1:0] out_pl_p0;
    logic [PW-1:0] skid_pl_p0;
    logic          load;

    // Stage p0: output register plus one skid entry, so the arbiter can keep
    // accepting while the output is stalled for one cycle.
    assign arb_ready = !skid_vld_p0;
    assign load      = !out_vld_p0 || ready_out;

    always_ff @(posedge clk) begin
      if (reset) begin
        out_vld_p0  <= 1'b0;
        skid_vld_p0 <= 1'b0;
      end else if (load) begin
        out_vld_p0  <= skid_vld_p0 || grant_valid;
        skid_vld_p0 <= 1'b0;
      end else if (grant_valid && !skid_vld_p0) begin
        skid_vld_p0 <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (load)
        out_pl_p0 <= skid_vld_p0 ? skid_pl_p0 : arb_pl;
      if (!load && !skid_vld_p0)
        skid_pl_p0 <= arb_pl;
    end

    assign valid_out = out_vld_p0;
    assign {sel_out, last_out, data_out} = out_pl_p0;
  end

  // A requester that raised valid must hold it and its beat until it fires.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_proto
    a_hold : assert property (@(posedge clk) disable iff (reset)
      (!reset && valid_in[i] && !ready_in[i]) |=>
        (valid_in[i] && $stable(last_in[i]) && $stable(data_in[i*DATAW +: DATAW])));
  end

endmodule

// File: tb/tb_vx_packet_arb.sv
// Scoreboard bench for vx_packet_arb: dut_a (4 inputs, quota 1, combinational
// output) and dut_b (3 inputs, quota 2, buffered output). Per-requester source
// queues feed beats; expected output beats are queued in arbitration order.
module tb_vx_packet_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  va, la, ra;
  logic [31:0] da;
  logic        vo_a, lo_a, ro_a;
  logic [7:0]  do_a;
  logic [1:0]  so_a;

  logic [2:0]  vb, lb, rb;
  logic [23:0] db;
  logic        vo_b, lo_b, ro_b;
  logic [7:0]  do_b;
  logic [1:0]  so_b;

`ifdef VX_PACKET_ARB_PERF_EN
  logic [31:0] perf_a, perf_b;
`endif

  vx_packet_arb #(.NUM_INPUTS(4), .DATAW(8), .QUOTA(1), .OUT_BUF(0)) dut_a (
    .clk(clk), .reset(rst), .valid_in(va), .data_in(da), .last_in(la), .ready_in(ra),
`ifdef VX_PACKET_ARB_PERF_EN
    .perf_hol_stalls(perf_a),
`endif
    .valid_out(vo_a), .data_out(do_a), .last_out(lo_a), .sel_out(so_a), .ready_out(ro_a));

  vx_packet_arb #(.NUM_INPUTS(3), .DATAW(8), .QUOTA(2), .OUT_BUF(2)) dut_b (
    .clk(clk), .reset(rst), .valid_in(vb), .data_in(db), .last_in(lb), .ready_in(rb),
`ifdef VX_PACKET_ARB_PERF_EN
    .perf_hol_stalls(perf_b),
`endif
    .valid_out(vo_b), .data_out(do_b), .last_out(lo_b), .sel_out(so_b), .ready_out(ro_b));

  // Source entry: {bubble, last, data}; expected entry: {sel, last, data}
  logic [9:0]  src_a[4][$];
  logic [9:0]  src_b[3][$];
  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];

  int n_chk = 0, n_pass = 0;
  int probe = 0;
  bit chk_onehot = 0, mon_t2 = 0, toggle_b = 0;
  int bub = 0, leak = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] bd(input int i, input int tag, input int b);
    return {i[1:0], tag[2:0], b[2:0]};
  endfunction

  task automatic pkt_a(input int i, input int n, input int tag);
    for (int b = 0; b < n; b++) src_a[i].push_back({1'b0, b == n - 1, bd(i, tag, b)});
  endtask
  task automatic pkt_b(input int i, input int n, input int tag);
    for (int b = 0; b < n; b++) src_b[i].push_back({1'b0, b == n - 1, bd(i, tag, b)});
  endtask
  task automatic exp_pkt_a(input int i, input int n, input int tag);
    for (int b = 0; b < n; b++) exp_a.push_back({i[1:0], b == n - 1, bd(i, tag, b)});
  endtask
  task automatic exp_pkt_b(input int i, input int n, input int tag);
    for (int b = 0; b < n; b++) exp_b.push_back({i[1:0], b == n - 1, bd(i, tag, b)});
  endtask

  function automatic int pending();
    int s = exp_a.size() + exp_b.size();
    for (int i = 0; i < 4; i++) s += src_a[i].size();
    for (int i = 0; i < 3; i++) s += src_b[i].size();
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_a[i].size() == 0 || src_a[i][0][9]) begin
        va[i] = 1'b0; la[i] = 1'b0; da[i*8 +: 8] = 8'h00;
      end else begin
        va[i] = 1'b1; la[i] = src_a[i][0][8]; da[i*8 +: 8] = src_a[i][0][7:0];
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (src_b[i].size() == 0 || src_b[i][0][9]) begin
        vb[i] = 1'b0; lb[i] = 1'b0; db[i*8 +: 8] = 8'h00;
      end else begin
        vb[i] = 1'b1; lb[i] = src_b[i][0][8]; db[i*8 +: 8] = src_b[i][0][7:0];
      end
    end
  endtask

  task automatic cycle();
    logic [3:0] fa;
    logic [2:0] fb;
    @(negedge clk);
    if (vo_a && ro_a) begin
      if (exp_a.size() == 0) check_val("a_extra_beat", 32'({so_a, lo_a, do_a}), 32'h800);
      else check_val("a_beat", 32'({so_a, lo_a, do_a}), 32'(exp_a.pop_front()));
    end
    if (vo_b && ro_b) begin
      if (exp_b.size() == 0) check_val("b_extra_beat", 32'({so_b, lo_b, do_b}), 32'h800);
      else check_val("b_beat", 32'({so_b, lo_b, do_b}), 32'(exp_b.pop_front()));
    end
    if (chk_onehot) check_val("t1_ready_onehot", 32'($countones(ra) <= 1), 32'd1);
    if (mon_t2 && !vo_a && (va != 4'b0)) begin
      bub++;
      if ((ra & 4'b1101) != 4'b0) leak++;
    end
    case (probe)
      1: begin
        check_val("rst_valid_out_a", 32'(vo_a), 32'd0);
        check_val("rst_ready_in_a", 32'(ra), 32'd0);
        check_val("rst_valid_out_b", 32'(vo_b), 32'd0);
        check_val("rst_ready_in_b", 32'(rb), 32'd0);
      end
      5: check_val("t5_valid_out_during_reset", 32'(vo_a), 32'd0);
      6: check_val("t6_same_cycle_grant", 32'(ra), 32'b1000);
      7: begin
        check_val("t5_valid_out_after_reset", 32'(vo_a), 32'd0);
        check_val("t5_ready_in_after_reset", 32'(ra), 32'd0);
      end
      default: ;
    endcase
    probe = 0;
    fa = va & ra;
    fb = vb & rb;
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        if (src_a[i].size() > 0 && (fa[i] || src_a[i][0][9])) void'(src_a[i].pop_front());
      for (int i = 0; i < 3; i++)
        if (src_b[i].size() > 0 && (fb[i] || src_b[i][0][9])) void'(src_b[i].pop_front());
    end
    if (toggle_b) ro_b = ~ro_b;
    drive();
  endtask

  task automatic drain(input int max_cyc, input string tag);
    int n = 0;
    while (pending() != 0 && n < max_cyc) begin
      cycle();
      n++;
    end
    check_val(tag, 32'(pending()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ro_a = 1'b1; ro_b = 1'b1;
    va = '0; la = '0; da = '0; vb = '0; lb = '0; db = '0;
    cycle(); cycle();
    rst = 1'b0;
    probe = 1;
    cycle();

    // Only input 3 valid with rr_ptr=0: granted in the same cycle
    pkt_a(3, 2, 0); exp_pkt_a(3, 2, 0);
    drive(); probe = 6;
    drain(20, "t6_drain");
    // Pointer wrapped 3->0: input 1 beats input 3
    pkt_a(1, 1, 1); pkt_a(3, 1, 1);
    exp_pkt_a(1, 1, 1); exp_pkt_a(3, 1, 1);
    drive();
    drain(20, "t6_wrap_drain");

    // All inputs stream 3-beat packets
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) begin
        pkt_a(i, 3, p + 2);
        exp_pkt_a(i, 3, p + 2);
      end
    chk_onehot = 1; drive();
    drain(60, "t1_drain");
    chk_onehot = 0;

    // Lock holder 1 idles 3 cycles mid-packet while input 2 waits
    for (int b = 0; b < 4; b++) begin
      if (b == 2) repeat (3) src_a[1].push_back(10'h200);
      src_a[1].push_back({1'b0, b == 3, bd(1, 4, b)});
    end
    pkt_a(2, 1, 4);
    exp_pkt_a(1, 4, 4); exp_pkt_a(2, 1, 4);
    bub = 0; leak = 0; mon_t2 = 1; drive();
    drain(30, "t2_drain");
    mon_t2 = 0;
    check_val("t2_bubble_cycles", 32'(bub), 32'd3);
    check_val("t2_other_ready_in_bubbles", 32'(leak), 32'd0);
`ifdef VX_PACKET_ARB_PERF_EN
    check_val("t2_perf_hol_stalls", perf_a, 32'd3);
`endif

    // Reset during beat 2 of a 4-beat packet on input 3
    pkt_a(3, 4, 5);
    exp_a.push_back({2'd3, 1'b0, bd(3, 5, 0)});
    drive();
    cycle();
    rst = 1'b1; probe = 5;
    cycle();
    src_a[3].delete();
    rst = 1'b0; drive(); probe = 7;
    cycle();
`ifdef VX_PACKET_ARB_PERF_EN
    check_val("t5_perf_cleared", perf_a, 32'd0);
`endif
    pkt_a(0, 1, 6); pkt_a(3, 1, 6);
    exp_pkt_a(0, 1, 6); exp_pkt_a(3, 1, 6);
    drive();
    drain(20, "t5_drain");

    // Quota 2 with single-beat packets on every input
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 3; i++) pkt_b(i, 1, p);
    exp_pkt_b(0, 1, 0); exp_pkt_b(0, 1, 1);
    exp_pkt_b(1, 1, 0); exp_pkt_b(1, 1, 1);
    exp_pkt_b(2, 1, 0); exp_pkt_b(2, 1, 1);
    exp_pkt_b(0, 1, 2); exp_pkt_b(1, 1, 2); exp_pkt_b(2, 1, 2);
    drive();
    repeat (11) cycle();
    check_val("t3_full_throughput", 32'(exp_b.size()), 32'd0);
    drain(10, "t3_drain");

    // Buffered output with ready_out toggling during multi-beat packets
    pkt_b(0, 4, 3); pkt_b(2, 2, 3);
    exp_pkt_b(2, 2, 3); exp_pkt_b(0, 4, 3);
    toggle_b = 1; ro_b = 1'b1; drive();
    drain(40, "t4_drain");
    toggle_b = 0; ro_b = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
